pcileech_tlps128_dw_unpack: RTL and testbench

Converts the 128-bit TLP-AXI-stream carried in `clk_pcie` (first flag, tlast, tkeepdw) into a 32-bit DW stream with per-DW first/last markers and full ready/valid backpressure. It is the 128→32 counterpart of the 32→128 TX packer. It sits between the RX TLP filter path and narrow 32-bit consumers that cannot take four lanes per cycle. It also flags malformed keep patterns and packet-sequence violations, and counts completed packets.

---
 rtl/pcileech_tlp_dw_pkg.sv | 50 +++++
 rtl/pcileech_tlps128_dw_unpack.sv | 147 ++++++++++++++
 tb/tb_pcileech_tlps128_dw_unpack.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcileech_tlp_dw_pkg.sv
// Shared types and keep-decode helpers for the 128-bit to 32-bit TLP DW unpacker.
package pcileech_tlp_dw_pkg;

    localparam int unsigned DW_W    = 32;
    localparam int unsigned BEAT_DW = 4;
    localparam int unsigned BEAT_W  = DW_W * BEAT_DW;
    localparam int unsigned NDW_W   = 3;
    localparam int unsigned IDX_W   = 2;

    localparam logic [BEAT_DW-1:0] KEEP_1DW = 4'b0001;
    localparam logic [BEAT_DW-1:0] KEEP_2DW = 4'b0011;
    localparam logic [BEAT_DW-1:0] KEEP_3DW = 4'b0111;
    localparam logic [BEAT_DW-1:0] KEEP_4DW = 4'b1111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic [NDW_W-1:0]  ndw;
        logic              first;
        logic              last;
    } hold_t;

    // DW count covered by a keep mask: highest set bit + 1, or 0 for an empty mask.
    function automatic logic [NDW_W-1:0] keep2ndw(input logic [BEAT_DW-1:0] keep);
        logic [NDW_W-1:0] n;
        n = 3'd0;
        if (keep[3])      n = 3'd4;
        else if (keep[2]) n = 3'd3;
        else if (keep[1]) n = 3'd2;
        else if (keep[0]) n = 3'd1;
        return n;
    endfunction

    // Non-last beats must be full; a last beat may be any contiguous low-aligned mask.
    function automatic logic keep_legal(input logic [BEAT_DW-1:0] keep, input logic last);
        logic ok;
        if (last) begin
            ok = (keep == KEEP_1DW) || (keep == KEEP_2DW) ||
                 (keep == KEEP_3DW) || (keep == KEEP_4DW);
        end else begin
            ok = (keep == KEEP_4DW);
        end
        return ok;
    endfunction

endpackage

// File: rtl/pcileech_tlps128_dw_unpack.sv
// Splits 128-bit TLP beats into a 32-bit DW stream with first/last markers,
// backpressure, keep/sequence error flags and a completed-packet counter.
module pcileech_tlps128_dw_unpack
    import pcileech_tlp_dw_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk_pcie,
    input  logic              rst_n,
    input  logic [127:0]      s_tdata,
    input  logic [3:0]        s_tkeepdw,
    input  logic              s_tfirst,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [31:0]       m_data,
    output logic              m_first,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              err_keep,
    output logic              err_seq
);

    state_e             state_q, state_d;
    hold_t              hold_q, hold_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               in_pkt_q, in_pkt_d;
    logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;
    logic               err_keep_q, err_keep_d;
    logic               err_seq_q, err_seq_d;

    logic               hold_c;
    logic               last_dw_c;
    logic               beat_acc_c;
    logic               beat_use_c;
    logic [NDW_W-1:0]   beat_ndw_c;
    logic [DW_W-1:0]    dw_sel_c;

    // Handshake qualifiers; the reload slot opens only on the final DW handshake.
    always_comb begin
        hold_c     = (state_q == ST_HOLD);
        last_dw_c  = hold_c && ({1'b0, idx_q} == (hold_q.ndw - 3'd1));
        s_tready   = rst_n && ((state_q == ST_EMPTY) || (last_dw_c && m_ready));
        beat_acc_c = s_tvalid && s_tready;
        beat_ndw_c = keep2ndw(s_tkeepdw);
        beat_use_c = beat_acc_c && (beat_ndw_c != 3'd0);
    end

    always_comb begin
        dw_sel_c = hold_q.data[0 +: DW_W];
        case (idx_q)
            2'd1:    dw_sel_c = hold_q.data[DW_W*1 +: DW_W];
            2'd2:    dw_sel_c = hold_q.data[DW_W*2 +: DW_W];
            2'd3:    dw_sel_c = hold_q.data[DW_W*3 +: DW_W];
            default: dw_sel_c = hold_q.data[0 +: DW_W];
        endcase
    end

    assign m_valid   = hold_c;
    assign m_data    = hold_c ? dw_sel_c : 32'd0;
    assign m_first   = hold_c && hold_q.first && (idx_q == 2'd0);
    assign m_last    = last_dw_c && hold_q.last;
    assign pkt_count = pkt_count_q;
    assign err_keep  = err_keep_q;
    assign err_seq   = err_seq_q;

    // Next-state: FSM, holding register, packet tracking and counters.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        in_pkt_d    = in_pkt_q;
        pkt_count_d = pkt_count_q;
        err_keep_d  = err_keep_q;
        err_seq_d   = err_seq_q;

        case (state_q)
            ST_EMPTY: begin
                if (beat_use_c) begin
                    hold_d  = '{data: s_tdata, ndw: beat_ndw_c, first: s_tfirst, last: s_tlast};
                    idx_d   = 2'd0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    if (!last_dw_c) begin
                        idx_d = idx_q + 2'd1;
                    end else if (beat_use_c) begin
                        hold_d = '{data: s_tdata, ndw: beat_ndw_c, first: s_tfirst, last: s_tlast};
                        idx_d  = 2'd0;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: begin
                idx_d   = 2'd0;
                state_d = ST_EMPTY;
            end
        endcase

        if (beat_acc_c && !keep_legal(s_tkeepdw, s_tlast)) begin
            err_keep_d = 1'b1;
        end

        // Empty-keep beats are dropped without touching packet framing.
        if (beat_use_c) begin
            if (s_tfirst == in_pkt_q) begin
                err_seq_d = 1'b1;
            end
            if (s_tlast) begin
                in_pkt_d = 1'b0;
            end else if (s_tfirst) begin
                in_pkt_d = 1'b1;
            end
        end

        if (m_valid && m_ready && m_last) begin
            pkt_count_d = pkt_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            hold_q      <= '0;
            idx_q       <= '0;
            in_pkt_q    <= 1'b0;
            pkt_count_q <= '0;
            err_keep_q  <= 1'b0;
            err_seq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            in_pkt_q    <= in_pkt_d;
            pkt_count_q <= pkt_count_d;
            err_keep_q  <= err_keep_d;
            err_seq_q   <= err_seq_d;
        end
    end

endmodule

// File: tb/tb_pcileech_tlps128_dw_unpack.sv
// Scoreboard bench: directed beats push hand-computed DWs; a monitor pops and compares on each handshake.
module tb_pcileech_tlps128_dw_unpack;

    logic         clk_pcie = 1'b0;
    logic         rst_n    = 1'b0;
    logic [127:0] s_tdata  = '0;
    logic [3:0]   s_tkeepdw = '0;
    logic         s_tfirst = 1'b0;
    logic         s_tlast  = 1'b0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [31:0]  m_data;
    logic         m_first;
    logic         m_last;
    logic         m_valid;
    logic         m_ready  = 1'b1;
    logic [15:0]  pkt_count;
    logic         err_keep;
    logic         err_seq;

    typedef struct packed {
        logic [31:0] data;
        logic        first;
        logic        last;
    } exp_t;

    exp_t  exp_q[$];
    int    hs_cyc_q[$];
    bit    hs_rdy_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    hs_cnt = 0;
    bit    bp_mode = 1'b0;
    logic [3:0] bp_pat = 4'b1001;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_first;
    logic        prev_last;

    pcileech_tlps128_dw_unpack #(.CNT_W(16)) dut (
        .clk_pcie (clk_pcie),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tkeepdw(s_tkeepdw),
        .s_tfirst (s_tfirst),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_data   (m_data),
        .m_first  (m_first),
        .m_last   (m_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .pkt_count(pkt_count),
        .err_keep (err_keep),
        .err_seq  (err_seq)
    );

    always #5 clk_pcie = ~clk_pcie;

    always @(posedge clk_pcie) begin
        cyc = cyc + 1;
        #1;
        m_ready = bp_mode ? bp_pat[cyc % 4] : 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on every DW handshake, plus stall-stability checks.
    always @(negedge clk_pcie) begin
        exp_t e;
        if (!rst_n || !m_valid) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_data", 64'(m_data), 64'(prev_data));
                check("stall_first", 64'(m_first), 64'(prev_first));
                check("stall_last", 64'(m_last), 64'(prev_last));
            end
            if (!m_ready) begin
                check("stall_tready", 64'(s_tready), 64'd0);
            end else begin
                hs_cnt = hs_cnt + 1;
                hs_cyc_q.push_back(cyc);
                hs_rdy_q.push_back(s_tready);
                if (exp_q.size() == 0) begin
                    check("unexpected_dw", 64'(m_data), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("dw_data", 64'(m_data), 64'(e.data));
                    check("dw_first", 64'(m_first), 64'(e.first));
                    check("dw_last", 64'(m_last), 64'(e.last));
                end
            end
            prev_stall = !m_ready;
            prev_data  = m_data;
            prev_first = m_first;
            prev_last  = m_last;
        end
    end

    task automatic push(input logic [31:0] d, input logic f, input logic l);
        exp_t e;
        e.data = d; e.first = f; e.last = l;
        exp_q.push_back(e);
    endtask

    // Present a beat from just after a rising edge; returns #1 after the accepting edge.
    task automatic send_beat(input logic [127:0] d, input logic [3:0] k,
                             input logic f, input logic l);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        s_tdata = d; s_tkeepdw = k; s_tfirst = f; s_tlast = l; s_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk_pcie);
            done = s_tready;
            n = n + 1;
            @(posedge clk_pcie);
            #1;
            if (!done && n > 200) begin
                check("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 200) begin
            @(posedge clk_pcie);
            #1;
            n = n + 1;
        end
        if (n >= 200) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [5:0] pat;
        int hs0;

        // Reset state
        #1;
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_data", 64'(m_data), 64'd0);
        check("rst_first_last", 64'({m_first, m_last}), 64'd0);
        check("rst_count", 64'(pkt_count), 64'd0);
        check("rst_errs", 64'({err_keep, err_seq}), 64'd0);
        repeat (3) @(posedge clk_pcie);
        #1;
        rst_n = 1'b1;
        @(posedge clk_pcie);
        #1;

        // 3-DW single-beat TLP
        push(32'h1111_0000, 1'b1, 1'b0);
        push(32'h1111_0001, 1'b0, 1'b0);
        push(32'h1111_0002, 1'b0, 1'b1);
        send_beat({32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000}, 4'b0111, 1'b1, 1'b1);
        check("lat_valid", 64'(m_valid), 64'd1);
        check("lat_data", 64'(m_data), 64'h1111_0000);
        wait_drain();
        check("t3_count", 64'(pkt_count), 64'd1);
        check("t3_errs", 64'({err_keep, err_seq}), 64'd0);

        // 6-DW TLP over two beats, gap-free source
        hs_cyc_q.delete();
        hs_rdy_q.delete();
        push(32'h2222_0000, 1'b1, 1'b0);
        push(32'h2222_0001, 1'b0, 1'b0);
        push(32'h2222_0002, 1'b0, 1'b0);
        push(32'h2222_0003, 1'b0, 1'b0);
        push(32'h2222_0004, 1'b0, 1'b0);
        push(32'h2222_0005, 1'b0, 1'b1);
        send_beat({32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000}, 4'b1111, 1'b1, 1'b0);
        send_beat({32'h2222_00FF, 32'h2222_00FE, 32'h2222_0005, 32'h2222_0004}, 4'b0011, 1'b0, 1'b1);
        wait_drain();
        check("t6_hs_num", 64'(hs_cyc_q.size()), 64'd6);
        if (hs_cyc_q.size() == 6) begin
            pat = '0;
            for (int i = 0; i < 6; i++) pat[i] = hs_rdy_q[i];
            check("t6_tready_pat", 64'(pat), 64'b101000);
            check("t6_no_bubble", 64'(hs_cyc_q[5] - hs_cyc_q[0]), 64'd5);
        end
        check("t6_count", 64'(pkt_count), 64'd2);

        // Backpressure on a 4-DW beat
        hs0 = hs_cnt;
        bp_mode = 1'b1;
        push(32'h3333_0000, 1'b1, 1'b0);
        push(32'h3333_0001, 1'b0, 1'b0);
        push(32'h3333_0002, 1'b0, 1'b0);
        push(32'h3333_0003, 1'b0, 1'b1);
        send_beat({32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000}, 4'b1111, 1'b1, 1'b1);
        wait_drain();
        bp_mode = 1'b0;
        check("bp_hs", 64'(hs_cnt - hs0), 64'd4);
        check("bp_count", 64'(pkt_count), 64'd3);

        // Illegal keep: short non-last beat, then sparse last beat
        push(32'h4444_0000, 1'b1, 1'b0);
        push(32'h4444_0001, 1'b0, 1'b0);
        push(32'h4444_0002, 1'b0, 1'b0);
        push(32'h4444_0010, 1'b0, 1'b0);
        push(32'h4444_0011, 1'b0, 1'b0);
        push(32'h4444_0012, 1'b0, 1'b1);
        send_beat({32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000}, 4'b0111, 1'b1, 1'b0);
        check("bk_err_keep", 64'(err_keep), 64'd1);
        send_beat({32'h4444_0013, 32'h4444_0012, 32'h4444_0011, 32'h4444_0010}, 4'b0101, 1'b0, 1'b1);
        wait_drain();
        check("bk_count", 64'(pkt_count), 64'd4);
        check("bk_err_seq", 64'(err_seq), 64'd0);

        // Sequence error: second first while a packet is open
        push(32'h5555_0000, 1'b1, 1'b0);
        push(32'h5555_0001, 1'b0, 1'b0);
        push(32'h5555_0002, 1'b0, 1'b0);
        push(32'h5555_0003, 1'b0, 1'b0);
        push(32'h5555_0010, 1'b1, 1'b1);
        send_beat({32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000}, 4'b1111, 1'b1, 1'b0);
        check("seq_before", 64'(err_seq), 64'd0);
        send_beat({32'h5555_0013, 32'h5555_0012, 32'h5555_0011, 32'h5555_0010}, 4'b0001, 1'b1, 1'b1);
        check("seq_after", 64'(err_seq), 64'd1);
        wait_drain();
        check("seq_count", 64'(pkt_count), 64'd5);

        // Empty keep is swallowed
        send_beat({4{32'h6666_6666}}, 4'b0000, 1'b1, 1'b1);
        check("k0_valid", 64'(m_valid), 64'd0);
        repeat (3) @(posedge clk_pcie);
        #1;
        check("k0_count", 64'(pkt_count), 64'd5);

        // Reset while draining at idx 1
        hs0 = hs_cnt;
        push(32'h7777_0000, 1'b1, 1'b0);
        send_beat({32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000}, 4'b1111, 1'b1, 1'b1);
        @(posedge clk_pcie);
        #1;
        check("rm_idx1_data", 64'(m_data), 64'h7777_0001);
        rst_n = 1'b0;
        #1;
        check("rm_valid", 64'(m_valid), 64'd0);
        check("rm_tready", 64'(s_tready), 64'd0);
        exp_q.delete();
        hs0 = hs_cnt;
        repeat (2) @(posedge clk_pcie);
        #2;
        rst_n = 1'b1;
        repeat (10) @(posedge clk_pcie);
        #1;
        check("rm_no_dw", 64'(hs_cnt - hs0), 64'd0);
        check("rm_valid_after", 64'(m_valid), 64'd0);
        check("rm_count", 64'(pkt_count), 64'd0);
        check("rm_errs", 64'({err_keep, err_seq}), 64'd0);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
